// File: rtl/credential_rom.sv
// Credential store: 5-bit slot address -> 16-bit BCD user ID + 24-bit BCD password + populated flag.
// Latency: 1 cycle, registered outputs, synchronous active-high reset clears the pending read.
// Backpressure: none, accepts a new address on every clock.
module credential_rom #(
  parameter int ADDR_W    = 5,
  parameter int UID_W     = 16,
  parameter int PW_W      = 24,
  parameter int NUM_USERS = 9
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] addr,
  output logic [UID_W-1:0]  q_uid,
  output logic [PW_W-1:0]   q_pw,
  output logic              valid
);

  typedef struct packed {
    logic             vld;
    logic [UID_W-1:0] uid;
    logic [PW_W-1:0]  pw;
  } entry_t;

  localparam entry_t EMPTY = '{vld: 1'b0, uid: '0, pw: '0};

  // Unpopulated slots return EMPTY so high addresses never alias onto low slots.
  function automatic entry_t lookup(input logic [ADDR_W-1:0] a);
    entry_t e;
    e = EMPTY;
    if (int'(a) < NUM_USERS) begin
      case (int'(a))
        0: e = '{vld: 1'b1, uid: 16'h1001, pw: 24'h246810};
        1: e = '{vld: 1'b1, uid: 16'h1002, pw: 24'h135791};
        2: e = '{vld: 1'b1, uid: 16'h1003, pw: 24'h111111};
        3: e = '{vld: 1'b1, uid: 16'h1004, pw: 24'h222222};
        4: e = '{vld: 1'b1, uid: 16'h1005, pw: 24'h314159};
        5: e = '{vld: 1'b1, uid: 16'h1006, pw: 24'h271828};
        6: e = '{vld: 1'b1, uid: 16'h1007, pw: 24'h123456};
        7: e = '{vld: 1'b1, uid: 16'h1008, pw: 24'h654321};
        8: e = '{vld: 1'b1, uid: 16'h1009, pw: 24'h999999};
        default: e = EMPTY;
      endcase
    end
    return e;
  endfunction

  entry_t rd_dat;

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_dat <= EMPTY;
    end else begin
      rd_dat <= lookup(addr);
    end
  end

  assign q_uid = rd_dat.uid;
  assign q_pw  = rd_dat.pw;
  assign valid = rd_dat.vld;

endmodule

// File: tb/tb_credential_rom.sv
// Directed bench for credential_rom: reset, hold, full address sweep, unpopulated slots, mid-stream reset.
module tb_credential_rom;

  logic        clk;
  logic        rst;
  logic [4:0]  addr;
  logic [15:0] q_uid;
  logic [23:0] q_pw;
  logic        valid;

  int checks = 0;
  int errors = 0;

  logic [15:0] exp_uid [0:8];
  logic [23:0] exp_pw  [0:8];

  credential_rom dut (
    .clk   (clk),
    .rst   (rst),
    .addr  (addr),
    .q_uid (q_uid),
    .q_pw  (q_pw),
    .valid (valid)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic chk(input string tag, input logic [47:0] got, input logic [47:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle away from it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_slot(input string tag, input int a);
    if (a < 9) begin
      chk({tag, " uid"},   {32'h0, exp_uid[a]}, {32'h0, q_uid} == {32'h0, q_uid} ? {32'h0, exp_uid[a]} : 48'h0);
    end
  endtask

  task automatic expect_out(input string tag, input logic [15:0] uid, input logic [23:0] pw,
                            input logic v);
    chk({tag, " uid"},   {32'h0, q_uid}, {32'h0, uid});
    chk({tag, " pw"},    {24'h0, q_pw},  {24'h0, pw});
    chk({tag, " valid"}, {47'h0, valid}, {47'h0, v});
  endtask

  task automatic expect_tbl(input string tag, input int a);
    if (a < 9) expect_out(tag, exp_uid[a], exp_pw[a], 1'b1);
    else       expect_out(tag, 16'h0000, 24'h000000, 1'b0);
  endtask

  initial begin
    exp_uid[0] = 16'h1001; exp_pw[0] = 24'h246810;
    exp_uid[1] = 16'h1002; exp_pw[1] = 24'h135791;
    exp_uid[2] = 16'h1003; exp_pw[2] = 24'h111111;
    exp_uid[3] = 16'h1004; exp_pw[3] = 24'h222222;
    exp_uid[4] = 16'h1005; exp_pw[4] = 24'h314159;
    exp_uid[5] = 16'h1006; exp_pw[5] = 24'h271828;
    exp_uid[6] = 16'h1007; exp_pw[6] = 24'h123456;
    exp_uid[7] = 16'h1008; exp_pw[7] = 24'h654321;
    exp_uid[8] = 16'h1009; exp_pw[8] = 24'h999999;

    rst  = 1'b1;
    addr = 5'd0;
    for (int i = 0; i < 4; i++) begin
      step();
      expect_out($sformatf("reset%0d", i), 16'h0000, 24'h000000, 1'b0);
    end

    rst = 1'b0;
    step();
    expect_out("release", 16'h1001, 24'h246810, 1'b1);
    for (int i = 0; i < 9; i++) begin
      step();
      expect_out($sformatf("hold%0d", i), 16'h1001, 24'h246810, 1'b1);
    end

    for (int a = 0; a < 9; a++) begin
      addr = 5'(a);
      for (int c = 0; c < 9; c++) begin
        step();
        expect_tbl($sformatf("sweep_a%0d_c%0d", a, c), a);
      end
    end

    for (int a = 9; a < 32; a++) begin
      addr = 5'(a);
      step();
      expect_tbl($sformatf("empty_a%0d", a), a);
    end

    addr = 5'd9;
    step();
    expect_out("unpop9", 16'h0000, 24'h000000, 1'b0);
    addr = 5'd31;
    step();
    expect_out("unpop31", 16'h0000, 24'h000000, 1'b0);
    addr = 5'd1;
    step();
    expect_out("after_unpop", 16'h1002, 24'h135791, 1'b1);

    addr = 5'd5;
    step();
    expect_out("pre_rst5", 16'h1006, 24'h271828, 1'b1);
    rst = 1'b1;
    step();
    expect_out("mid_rst", 16'h0000, 24'h000000, 1'b0);
    rst = 1'b0;
    step();
    expect_out("post_rst5", 16'h1006, 24'h271828, 1'b1);

    addr = 5'd3;
    step();
    expect_out("b2b_3", 16'h1004, 24'h222222, 1'b1);
    addr = 5'd7;
    step();
    expect_out("b2b_7", 16'h1008, 24'h654321, 1'b1);
    addr = 5'd2;
    step();
    expect_out("b2b_2", 16'h1003, 24'h111111, 1'b1);

    // Address change lands only on the next edge, never before it.
    addr = 5'd8;
    #5;
    expect_out("no_comb_path", 16'h1003, 24'h111111, 1'b1);
    step();
    expect_out("lag_8", 16'h1009, 24'h999999, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
